// File: rtl/rr_mux_reg.sv
// rr_mux_reg: registered N:1 channel multiplexer with valid/ready handshakes.
// Selection is either a fixed channel address (mode=0) or round-robin
// arbitration among valid inputs (mode=1). The output is a single registered
// slot that can refill in the same cycle it drains, so it sustains one
// transfer per cycle.
// Optional feature: define RR_MUX_PARITY_EN to add a registered out_parity
// port carrying the XOR of the accepted word's bits.
`timescale 1ns/1ps

module rr_mux_reg #(
  parameter int N = 2,
  parameter int W = 1,
  parameter int A = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [A-1:0]     addr,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             addr_err,
`ifdef RR_MUX_PARITY_EN
  output logic             out_parity,
`endif
  output logic [A-1:0]     grant_id
);

  // Registered state
  logic [W-1:0] out_data_q,  out_data_d;
  logic         out_valid_q, out_valid_d;
  logic [A-1:0] grant_id_q,  grant_id_d;
  logic         addr_err_q,  addr_err_d;
  logic [A-1:0] ptr_q,       ptr_d;

  // Combinational grant path
  logic         load_en;
  logic         addr_ok;
  logic [N-1:0] fx_shift;
  logic         fx_vld;
  logic         rr_vld;
  logic [A-1:0] rr_idx;
  logic [A:0]   cand;
  logic [N-1:0] cand_shift;
  logic         grant_vld;
  logic [A-1:0] grant_idx;
  logic         xfer;
  logic [W-1:0] sel_data;
  logic [A:0]   ptr_nxt;

  // The slot can accept a new word when empty or when it drains this cycle.
  assign load_en = !out_valid_q || out_ready;

  // Fixed-address request: the address must name a real channel that is valid.
  always_comb begin
    addr_ok  = (32'(addr) < 32'(N));
    fx_shift = in_valid >> addr;
    fx_vld   = addr_ok && fx_shift[0];
  end

  // Round-robin search: first valid channel starting at ptr, wrapping at N.
  // The candidate index carries one extra bit so ptr+k never overflows
  // before the explicit wrap, which matters when N is not a power of two.
  always_comb begin
    rr_vld     = 1'b0;
    rr_idx     = '0;
    cand       = '0;
    cand_shift = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (A+1)'(k);
      if (cand >= (A+1)'(N)) begin
        cand = cand - (A+1)'(N);
      end
      cand_shift = in_valid >> cand;
      if (!rr_vld && cand_shift[0]) begin
        rr_vld = 1'b1;
        rr_idx = cand[A-1:0];
      end
    end
  end

  assign grant_vld = mode ? rr_vld : fx_vld;
  assign grant_idx = mode ? rr_idx : addr;
  assign xfer      = load_en && grant_vld;

  // Route the granted channel's data toward the output slot.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == A'(i)) begin
        sel_data = in_data[i*W +: W];
      end
    end
  end

  // Only the granted channel sees ready, and only when the slot can load.
  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign in_ready[gi] = xfer && (grant_idx == A'(gi));
  end

  // Next-state: load on transfer, clear valid on a drain, hold on stall.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    grant_id_d  = grant_id_q;
    ptr_d       = ptr_q;
    addr_err_d  = !mode && !addr_ok;
    ptr_nxt     = {1'b0, grant_idx} + (A+1)'(1);
    if (ptr_nxt == (A+1)'(N)) begin
      ptr_nxt = '0;
    end
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      grant_id_d  = grant_idx;
      // Fixed-mode transfers leave the round-robin position untouched.
      if (mode) begin
        ptr_d = ptr_nxt[A-1:0];
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_id_q  <= '0;
      addr_err_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      grant_id_q  <= grant_id_d;
      addr_err_q  <= addr_err_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant_id  = grant_id_q;
  assign addr_err  = addr_err_q;

`ifdef RR_MUX_PARITY_EN
  logic out_parity_q, out_parity_d;

  // Parity tracks out_data: loaded on a transfer, otherwise held.
  always_comb begin
    out_parity_d = xfer ? ^sel_data : out_parity_q;
  end

  // Parity register, cleared with the rest of the slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_parity_q <= 1'b0;
    end else begin
      out_parity_q <= out_parity_d;
    end
  end

  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed testbench for rr_mux_reg with a scoreboard of expected output words.
// Three instances: N=2/W=1, N=4/W=8 and N=3/W=8 (non-power-of-two channel count).
`timescale 1ns/1ps

module tb_rr_mux_reg;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Instance A: N=2, W=1, A=1
  logic [1:0] a_in_data, a_in_valid, a_in_ready;
  logic       a_mode, a_addr, a_out_data, a_out_valid, a_out_ready, a_addr_err, a_grant_id;
  // Instance B: N=4, W=8, A=2
  logic [31:0] b_in_data;
  logic [3:0]  b_in_valid, b_in_ready;
  logic        b_mode, b_out_valid, b_out_ready, b_addr_err;
  logic [1:0]  b_addr, b_grant_id;
  logic [7:0]  b_out_data;
  // Instance C: N=3, W=8, A=2
  logic [23:0] c_in_data;
  logic [2:0]  c_in_valid, c_in_ready;
  logic        c_mode, c_out_valid, c_out_ready, c_addr_err;
  logic [1:0]  c_addr, c_grant_id;
  logic [7:0]  c_out_data;
`ifdef RR_MUX_PARITY_EN
  logic a_par, b_par, c_par;
`endif

  rr_mux_reg #(.N(2), .W(1), .A(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .mode(a_mode), .addr(a_addr), .out_data(a_out_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .addr_err(a_addr_err),
`ifdef RR_MUX_PARITY_EN
    .out_parity(a_par),
`endif
    .grant_id(a_grant_id));

  rr_mux_reg #(.N(4), .W(8), .A(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .mode(b_mode), .addr(b_addr), .out_data(b_out_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .addr_err(b_addr_err),
`ifdef RR_MUX_PARITY_EN
    .out_parity(b_par),
`endif
    .grant_id(b_grant_id));

  rr_mux_reg #(.N(3), .W(8), .A(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .mode(c_mode), .addr(c_addr), .out_data(c_out_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .addr_err(c_addr_err),
`ifdef RR_MUX_PARITY_EN
    .out_parity(c_par),
`endif
    .grant_id(c_grant_id));

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] sb_q[$];   // {grant_id[1:0], data[7:0]}

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] gid, input logic [7:0] data);
    sb_q.push_back({gid, data});
  endtask

  task automatic check_out(input string tag, input logic [7:0] od, input logic [1:0] og,
                           input logic ov);
    logic [9:0] e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed output word 0x%0h expected empty scoreboard", tag, od);
    end else begin
      e = sb_q.pop_front();
      $display("[TB] %s out_data=0x%0h grant_id=%0d out_valid=%0b", tag, od, og, ov);
      chk({tag, "_valid"}, 32'(ov), 32'd1);
      chk({tag, "_data"},  32'(od), 32'(e[7:0]));
      chk({tag, "_gid"},   32'(og), 32'(e[9:8]));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    a_in_data = '0; a_in_valid = '0; a_mode = 1'b0; a_addr = '0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = '0; b_mode = 1'b0; b_addr = '0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_valid = '0; c_mode = 1'b0; c_addr = '0; c_out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_b_valid", 32'(b_out_valid), 32'd0);
    chk("rst_b_data",  32'(b_out_data),  32'd0);
    chk("rst_b_gid",   32'(b_grant_id),  32'd0);
    chk("rst_b_err",   32'(b_addr_err),  32'd0);
    chk("rst_a_valid", 32'(a_out_valid), 32'd0);
    chk("rst_c_valid", 32'(c_out_valid), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // A: classic 2:1 mux, ch0=1, ch1=0
    a_in_data = 2'b01; a_in_valid = 2'b11; a_mode = 1'b0; a_addr = 1'b0;
    settle();
    chk("a_rdy_addr0", 32'(a_in_ready), 32'b01);
    push(2'd0, 8'h01);
    tick();
    check_out("a_addr0", {7'b0, a_out_data}, {1'b0, a_grant_id}, a_out_valid);
    chk("a_err0", 32'(a_addr_err), 32'd0);
    a_addr = 1'b1;
    settle();
    chk("a_rdy_addr1", 32'(a_in_ready), 32'b10);
    push(2'd1, 8'h00);
    tick();
    check_out("a_addr1", {7'b0, a_out_data}, {1'b0, a_grant_id}, a_out_valid);
    a_in_valid = 2'b00;
    tick();
    chk("a_drain_valid", 32'(a_out_valid), 32'd0);

    // C: N=3, fixed mode then bad address
    c_in_data = {8'hCC, 8'hBB, 8'hAA}; c_in_valid = 3'b111; c_mode = 1'b0; c_addr = 2'd0;
    settle();
    push(2'd0, 8'hAA);
    tick();
    check_out("c_fix0", c_out_data, c_grant_id, c_out_valid);
    c_addr = 2'd3;
    settle();
    chk("c_bad_rdy", 32'(c_in_ready), 32'b000);
    tick();
    chk("c_bad_err",   32'(c_addr_err),  32'd1);
    chk("c_bad_valid", 32'(c_out_valid), 32'd0);
    chk("c_bad_hold",  32'(c_out_data),  32'hAA);
    // C: round-robin wrap 2 -> 0 with N=3; addr=3 is harmless in this mode
    c_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk($sformatf("c_rr%0d_rdy", k), 32'(c_in_ready), 32'(1 << (k % 3)));
      push(2'(k % 3), 8'hAA + 8'(17 * (k % 3)));
      tick();
      check_out($sformatf("c_rr%0d", k), c_out_data, c_grant_id, c_out_valid);
      chk($sformatf("c_rr%0d_err", k), 32'(c_addr_err), 32'd0);
    end
    // Park C with a pending address error so the reset check later is meaningful
    c_in_valid = 3'b000; c_mode = 1'b0; c_addr = 2'd3;
    tick();

    // B: round-robin over four valid channels, wrap 3 -> 0
    b_in_data = {8'h44, 8'h33, 8'h22, 8'h11}; b_in_valid = 4'b1111; b_mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("b_rr%0d_rdy", k), 32'(b_in_ready), 32'(1 << (k % 4)));
      push(2'(k % 4), 8'h11 * 8'((k % 4) + 1));
      tick();
      check_out($sformatf("b_rr%0d", k), b_out_data, b_grant_id, b_out_valid);
    end

    // B: only ch2 and ch0 valid, ptr=1 -> ch2, ch0, ch2
    b_in_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("b_sp%0d_rdy", k), 32'(b_in_ready), (k == 1) ? 32'b0001 : 32'b0100);
      if (k == 1) push(2'd0, 8'h11);
      else        push(2'd2, 8'h33);
      tick();
      check_out($sformatf("b_sp%0d", k), b_out_data, b_grant_id, b_out_valid);
    end

    // B: backpressure holds the word and blocks every input
    b_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("b_stall%0d_rdy", k), 32'(b_in_ready), 32'b0000);
      tick();
      chk($sformatf("b_stall%0d_data", k),  32'(b_out_data),  32'h33);
      chk($sformatf("b_stall%0d_gid", k),   32'(b_grant_id),  32'd2);
      chk($sformatf("b_stall%0d_valid", k), 32'(b_out_valid), 32'd1);
    end
    // Release: the next word loads in the same cycle the held one drains
    b_out_ready = 1'b1;
    settle();
    chk("b_release_rdy", 32'(b_in_ready), 32'b0001);
    push(2'd0, 8'h11);
    tick();
    check_out("b_release", b_out_data, b_grant_id, b_out_valid);

    // B: drain with no input: valid drops, data and grant_id hold
    b_in_valid = 4'b0000;
    tick();
    chk("b_drain_valid", 32'(b_out_valid), 32'd0);
    chk("b_drain_data",  32'(b_out_data),  32'h11);
    chk("b_drain_gid",   32'(b_grant_id),  32'd0);

    // B: fixed transfer must not move the round-robin pointer (still 1)
    b_in_valid = 4'b1111; b_mode = 1'b0; b_addr = 2'd2;
    settle();
    chk("b_fix_rdy", 32'(b_in_ready), 32'b0100);
    push(2'd2, 8'h33);
    tick();
    check_out("b_fix", b_out_data, b_grant_id, b_out_valid);
    chk("b_fix_err", 32'(b_addr_err), 32'd0);
    b_mode = 1'b1;
    settle();
    chk("b_ptrkeep_rdy", 32'(b_in_ready), 32'b0010);
    push(2'd1, 8'h22);
    tick();
    check_out("b_ptrkeep", b_out_data, b_grant_id, b_out_valid);

    // Asynchronous reset mid-stream (B holds a word, ptr=2; C has addr_err=1)
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_b_valid", 32'(b_out_valid), 32'd0);
    chk("mrst_b_data",  32'(b_out_data),  32'd0);
    chk("mrst_b_gid",   32'(b_grant_id),  32'd0);
    chk("mrst_c_err",   32'(c_addr_err),  32'd0);
`ifdef RR_MUX_PARITY_EN
    chk("mrst_b_par",   32'(b_par),       32'd0);
`endif
    tick();
    reset_n = 1'b1;
    settle();
    chk("post_rst_rdy", 32'(b_in_ready), 32'b0001);
    push(2'd0, 8'h11);
    tick();
    check_out("post_rst", b_out_data, b_grant_id, b_out_valid);

    // Parity-relevant data words on channel 0 in fixed mode
    b_mode = 1'b0; b_addr = 2'd0; b_in_data[7:0] = 8'h07;
    settle();
    push(2'd0, 8'h07);
    tick();
    check_out("par07", b_out_data, b_grant_id, b_out_valid);
`ifdef RR_MUX_PARITY_EN
    chk("par07_bit", 32'(b_par), 32'd1);
`endif
    b_in_data[7:0] = 8'h03;
    settle();
    push(2'd0, 8'h03);
    tick();
    check_out("par03", b_out_data, b_grant_id, b_out_valid);
`ifdef RR_MUX_PARITY_EN
    chk("par03_bit", 32'(b_par), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
